// File: rtl/mat_vec_sequencer.sv
// Host-side sequencer for one MatVecUnit: command FIFO, one-op-per-cycle issue register, 2-entry result FIFO.
// Optional performance counters are built in when MAT_VEC_SEQ_PERF_EN is defined.
package mat_vec_sequencer_pkg;
  localparam int unsigned LANE_W = 32;
  typedef logic [LANE_W-1:0] lane_t;  // IEEE-754 single-precision bit pattern
  typedef enum logic [1:0] {
    OP_ZERO = 2'd0,
    OP_LOAD = 2'd1,
    OP_ADD  = 2'd2
  } MatVecUnitOp_t;
endpackage

module mat_vec_sequencer
  import mat_vec_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH     = 128,
  parameter int unsigned CMD_DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  MatVecUnitOp_t           cmd_op,
  input  lane_t [WIDTH-1:0]       cmd_data,
  output MatVecUnitOp_t           unit_op,
  output lane_t [WIDTH-1:0]       unit_data_in,
  input  lane_t [WIDTH-1:0]       unit_data_out,
  output logic                    res_valid,
  input  logic                    res_ready,
  output lane_t [WIDTH-1:0]       res_data,
  output logic                    err_unloaded,
  output logic                    busy
`ifdef MAT_VEC_SEQ_PERF_EN
  ,
  output logic [31:0]             perf_issue_cnt,
  output logic [31:0]             perf_stall_cnt
`endif
);

  localparam int unsigned PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef lane_t [WIDTH-1:0] vec_t;
  typedef struct packed {
    MatVecUnitOp_t op;
    vec_t          data;
  } cmd_t;

  cmd_t             cmd_mem [CMD_DEPTH];
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cmd_cnt;
  logic [CNT_W-1:0] cmd_cnt_nxt;
  logic             head_valid;
  logic             head_res;
  logic             issuable;
  logic             push;
  logic             pop;
  logic             issue_res_q;   // commanded ZERO/ADD sits in the issue register
  logic             loaded;
  logic [1:0]       res_cnt;
  logic [1:0]       res_cnt_nxt;
  logic [1:0]       res_fill;
  logic [1:0]       credits;
  logic             res_push;
  logic             res_pop;
  vec_t             res_tail;

  assign head = cmd_mem[rd_ptr];

  // Issue decision and occupancy bookkeeping
  always_comb begin
    head_valid  = 1'b0;
    head_res    = 1'b0;
    credits     = 2'd0;
    issuable    = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    res_push    = 1'b0;
    res_pop     = 1'b0;
    res_fill    = 2'd0;
    cmd_cnt_nxt = cmd_cnt;
    res_cnt_nxt = res_cnt;

    head_valid  = (cmd_cnt != '0);
    head_res    = (head.op != OP_LOAD);
    credits     = 2'd2 - res_cnt - {1'b0, issue_res_q};
    issuable    = head_valid && (!head_res || (credits != 2'd0));
    push        = cmd_valid && cmd_ready;
    pop         = issuable;
    res_push    = issue_res_q;
    res_pop     = res_valid && res_ready;
    res_fill    = res_cnt - 2'(res_pop);
    cmd_cnt_nxt = cmd_cnt + CNT_W'(push) - CNT_W'(pop);
    res_cnt_nxt = res_cnt + 2'(res_push) - 2'(res_pop);
  end

  // Command storage carries no reset; occupancy alone defines validity
  always_ff @(posedge clock) begin
    if (push) begin
      cmd_mem[wr_ptr] <= cmd_t'{op: cmd_op, data: cmd_data};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cmd_cnt   <= '0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      cmd_cnt   <= cmd_cnt_nxt;
      cmd_ready <= (cmd_cnt_nxt != CNT_W'(CMD_DEPTH));
      busy      <= (cmd_cnt_nxt != '0) || pop || (res_cnt_nxt != 2'd0);
    end
  end

  // Issue register: idle cycles drive a ZERO with zero data so the unit sees no writes
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      unit_op      <= OP_ZERO;
      unit_data_in <= '0;
      issue_res_q  <= 1'b0;
      loaded       <= 1'b0;
      err_unloaded <= 1'b0;
    end else begin
      if (pop) begin
        unit_op      <= head.op;
        unit_data_in <= (head.op == OP_ZERO) ? '0 : head.data;
        issue_res_q  <= head_res;
        if (head.op == OP_LOAD) loaded <= 1'b1;
        if ((head.op == OP_ADD) && !loaded) err_unloaded <= 1'b1;
      end else begin
        unit_op      <= OP_ZERO;
        unit_data_in <= '0;
        issue_res_q  <= 1'b0;
      end
    end
  end

  // Two-entry result FIFO: res_data is the head, res_tail the second slot
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      res_cnt   <= 2'd0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_tail  <= '0;
    end else begin
      res_cnt   <= res_cnt_nxt;
      res_valid <= (res_cnt_nxt != 2'd0);
      if (res_pop && (res_cnt == 2'd2)) res_data <= res_tail;
      if (res_push) begin
        if (res_fill == 2'd0) res_data <= unit_data_out;
        else                  res_tail <= unit_data_out;
      end
    end
  end

`ifdef MAT_VEC_SEQ_PERF_EN
  // Saturating counters: commanded ops issued, and cycles a present head could not issue
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (pop && (perf_issue_cnt != '1)) perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if (head_valid && !issuable && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mat_vec_sequencer.sv
// Self-checking bench for mat_vec_sequencer with a behavioural MatVecUnit and a command-level result model.
module tb_mat_vec_sequencer;
  import mat_vec_sequencer_pkg::*;

  localparam int unsigned W     = 16;
  localparam int unsigned DEPTH = 4;
  typedef logic [W-1:0][31:0] vec_t;

  logic          clock;
  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  MatVecUnitOp_t cmd_op;
  vec_t          cmd_data;
  MatVecUnitOp_t unit_op;
  vec_t          unit_data_in;
  vec_t          unit_data_out;
  logic          res_valid;
  logic          res_ready;
  vec_t          res_data;
  logic          err_unloaded;
  logic          busy;
`ifdef MAT_VEC_SEQ_PERF_EN
  logic [31:0]   perf_issue_cnt;
  logic [31:0]   perf_stall_cnt;
`endif

  mat_vec_sequencer #(.WIDTH(W), .CMD_DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .unit_op(unit_op), .unit_data_in(unit_data_in), .unit_data_out(unit_data_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .err_unloaded(err_unloaded), .busy(busy)
`ifdef MAT_VEC_SEQ_PERF_EN
    , .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clock = ~clock;

  // Non-negative integers (< 2^24) encoded exactly as single-precision floats
  function automatic logic [31:0] int_to_f32(input int unsigned v);
    int e;
    logic [31:0] sh;
    if (v == 0) return 32'h0;
    e = 0;
    for (int i = 0; i < 24; i++) if (v[i]) e = i;
    sh = v << (23 - e);
    return {1'b0, 8'(127 + e), sh[22:0]};
  endfunction

  function automatic int unsigned f32_to_int(input logic [31:0] f);
    int e;
    logic [31:0] m;
    if (f[30:23] == 8'd0) return 0;
    e = int'(f[30:23]) - 127;
    if (e < 0) return 0;
    m = {8'd0, 1'b1, f[22:0]};
    return m >> (23 - e);
  endfunction

  function automatic vec_t vec_of(input int unsigned v);
    vec_t r;
    for (int i = 0; i < W; i++) r[i] = int_to_f32(v);
    return r;
  endfunction

  // Behavioural MatVecUnit: memory with no reset, combinational ADD/ZERO output
  vec_t unit_mem;
  bit   mem_seeded = 1'b0;
  always @(posedge clock) begin
    if (!mem_seeded) begin
      unit_mem   <= vec_of(10);
      mem_seeded <= 1'b1;
    end else if (unit_op == OP_LOAD) begin
      unit_mem <= unit_data_in;
    end
  end
  always_comb begin
    unit_data_out = '0;
    if (unit_op == OP_ADD)
      for (int i = 0; i < W; i++)
        unit_data_out[i] = int_to_f32(f32_to_int(unit_data_in[i]) + f32_to_int(unit_mem[i]));
  end

  // Command-level reference: results follow command order; ADD = data + last LOADed vector
  vec_t        exp_q[$];
  int unsigned model_mem [W];
  bit          model_loaded;
  bit          model_err;
  int          n_cmp, n_fail, n_res, n_acc;
  int          load_run, max_load_run;
  bit          rand_done;

  task automatic chk1(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_vec(input string name, input vec_t act, input vec_t exp);
    int bad;
    n_cmp++;
    bad = -1;
    for (int i = W - 1; i >= 0; i--) if (act[i] !== exp[i]) bad = i;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: lane %0d got %0h expected %0h at %0t", name, bad, act[bad], exp[bad], $time);
    end
  endtask

  task automatic model_accept(input MatVecUnitOp_t op, input vec_t d);
    vec_t e;
    n_acc++;
    case (op)
      OP_LOAD: begin
        for (int i = 0; i < W; i++) model_mem[i] = f32_to_int(d[i]);
        model_loaded = 1'b1;
      end
      OP_ZERO: exp_q.push_back('0);
      default: begin
        for (int i = 0; i < W; i++) e[i] = int_to_f32(f32_to_int(d[i]) + model_mem[i]);
        if (!model_loaded) model_err = 1'b1;
        exp_q.push_back(e);
      end
    endcase
  endtask

  // Monitor: sampled mid-cycle, ahead of the edge that completes each handshake
  always @(negedge clock) begin
    if (reset_n) begin
      if (cmd_valid && cmd_ready) model_accept(cmd_op, cmd_data);
      if (unit_op == OP_LOAD) load_run++; else load_run = 0;
      if (load_run > max_load_run) max_load_run = load_run;
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          chk1("unexpected_res_valid", 32'(res_valid), 32'd0);
        end else begin
          chk_vec("res_data", res_data, exp_q[0]);
          if (res_ready) begin
            void'(exp_q.pop_front());
            n_res++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input MatVecUnitOp_t op, input vec_t d, output int waits);
    bit done;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    waits     = 0;
    done      = 1'b0;
    while (!done) begin
      @(negedge clock);
      if (cmd_ready) done = 1'b1;
      else if (waits >= 200) begin
        chk1("send_timeout", 32'd1, 32'd0);
        done = 1'b1;
      end else waits++;
      tick();
    end
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clock);
      if (!busy && exp_q.size() == 0) done = 1'b1;
    end
    if (!done) chk1(name, 32'd0, 32'd1);
    tick();
  endtask

  task automatic do_reset(input string name);
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    exp_q.delete();
    model_loaded = 1'b0;
    model_err    = 1'b0;
    n_acc        = 0;
    #1;
    chk1({name, "_unit_op"},   32'(unit_op), 32'(OP_ZERO));
    chk1({name, "_res_valid"}, 32'(res_valid), 32'd0);
    chk1({name, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
    chk1({name, "_busy"},      32'(busy), 32'd0);
    chk1({name, "_err"},       32'(err_unloaded), 32'd0);
    chk_vec({name, "_res_data"}, res_data, '0);
    repeat (2) @(posedge clock);
    #2;
    reset_n = 1'b1;
    tick();
    tick();
    chk1({name, "_rel_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk1({name, "_rel_busy"},      32'(busy), 32'd0);
  endtask

  typedef struct {
    MatVecUnitOp_t op;
    int unsigned   val;
    bit            has_res;
    int unsigned   res;
    bit            err;
  } rec_t;

  rec_t tbl [9];

  initial begin
    int   w, wsum, n0;
    bit   got;
    vec_t rv, r0, d;
    MatVecUnitOp_t op;

    // Unit memory holds 1.0 from the latency test when the table runs
    tbl[0] = '{OP_ADD,  5, 1'b1,  6, 1'b1};
    tbl[1] = '{OP_LOAD, 1, 1'b0,  0, 1'b1};
    tbl[2] = '{OP_ADD,  2, 1'b1,  3, 1'b1};
    tbl[3] = '{OP_ZERO, 7, 1'b1,  0, 1'b1};
    tbl[4] = '{OP_ADD,  4, 1'b1,  5, 1'b1};
    tbl[5] = '{OP_LOAD, 6, 1'b0,  0, 1'b1};
    tbl[6] = '{OP_ADD,  6, 1'b1, 12, 1'b1};
    tbl[7] = '{OP_ZERO, 0, 1'b1,  0, 1'b1};
    tbl[8] = '{OP_LOAD, 3, 1'b0,  0, 1'b1};

    clock = 1'b0; reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = OP_ZERO; cmd_data = '0; res_ready = 1'b1;
    n_cmp = 0; n_fail = 0; n_res = 0; n_acc = 0; load_run = 0; max_load_run = 0; rand_done = 1'b0;
    for (int i = 0; i < W; i++) model_mem[i] = 10;

    do_reset("rst0");

    // LOAD 1.0, ADD 2.0: result 3.0 two cycles after the ADD is accepted
    send(OP_LOAD, vec_of(1), w);
    send(OP_ADD, vec_of(2), w);
    cmd_valid = 1'b0;
    @(negedge clock); chk1("lat_c1_valid", 32'(res_valid), 32'd0);
    @(negedge clock); chk1("lat_c2_valid", 32'(res_valid), 32'd0);
    @(negedge clock); chk1("lat_c3_valid", 32'(res_valid), 32'd1);
    chk_vec("lat_res", res_data, vec_of(3));
    chk1("lat_err", 32'(err_unloaded), 32'd0);
    tick();
    wait_idle("lat_idle");

    do_reset("rst1");
    for (int k = 0; k < 9; k++) begin
      send(tbl[k].op, vec_of(tbl[k].val), w);
      cmd_valid = 1'b0;
      got = 1'b0;
      rv  = '0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clock);
        if (res_valid && !got) begin
          got = 1'b1;
          rv  = res_data;
        end
      end
      chk1("tbl_has_res", 32'(got), 32'(tbl[k].has_res));
      if (tbl[k].has_res) chk_vec("tbl_res", rv, vec_of(tbl[k].res));
      chk1("tbl_err", 32'(err_unloaded), 32'(tbl[k].err));
      tick();
    end

    // Back-pressure: two results held, remaining ADDs fill the command FIFO
    res_ready = 1'b0;
    n0 = n_res;
    send(OP_LOAD, vec_of(100), w);
    for (int k = 1; k <= 6; k++) send(OP_ADD, vec_of(k), w);
    cmd_valid = 1'b0;
    repeat (4) tick();
    @(negedge clock);
    chk1("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    chk1("bp_res_valid", 32'(res_valid), 32'd1);
    chk1("bp_busy", 32'(busy), 32'd1);
    chk_vec("bp_head", res_data, vec_of(101));
    r0 = res_data;
    repeat (3) @(negedge clock);
    chk_vec("bp_hold", res_data, r0);
    tick();
    res_ready = 1'b1;
    wait_idle("bp_drain");
    chk1("bp_count", 32'(n_res - n0), 32'd6);

    // Back-to-back LOAD stream: full-rate issue, no results
    n0 = n_res;
    wsum = 0;
    max_load_run = 0;
    for (int k = 0; k < DEPTH + 2; k++) begin
      for (int i = 0; i < W; i++) d[i] = int_to_f32($urandom_range(0, 1000));
      send(OP_LOAD, d, w);
      wsum += w;
    end
    cmd_valid = 1'b0;
    wait_idle("stream_idle");
    chk1("stream_waits", 32'(wsum), 32'd0);
    chk1("stream_run", 32'(max_load_run), 32'(DEPTH + 2));
    chk1("stream_no_res", 32'(n_res - n0), 32'd0);

    // Reset with results pending and ADDs queued: everything discarded
    res_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(OP_ADD, vec_of(1), w);
    cmd_valid = 1'b0;
    tick();
    do_reset("rst_mid");
    n0 = n_res;
    res_ready = 1'b1;
    repeat (10) tick();
    chk1("rst_mid_no_res", 32'(n_res - n0), 32'd0);

    // Random traffic with random result back-pressure
    fork
      begin
        for (int k = 0; k < 80; k++) begin
          case ($urandom_range(0, 3))
            0:       op = OP_ZERO;
            1:       op = OP_LOAD;
            default: op = OP_ADD;
          endcase
          for (int i = 0; i < W; i++) d[i] = int_to_f32($urandom_range(0, 1000));
          send(op, d, w);
          if ($urandom_range(0, 3) == 0) begin
            cmd_valid = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
          end
        end
        cmd_valid = 1'b0;
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          res_ready = 1'($urandom_range(0, 1));
          tick();
        end
        res_ready = 1'b1;
      end
    join
    wait_idle("rand_drain");
    chk1("rand_err", 32'(err_unloaded), 32'(model_err));
    chk1("rand_busy", 32'(busy), 32'd0);
`ifdef MAT_VEC_SEQ_PERF_EN
    chk1("perf_issue", perf_issue_cnt, 32'(n_acc));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
